// File: rtl/pmp_access_checker_pkg.sv
// Shared types and constants for the sequential PMP access checker.
package pmp_access_checker_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_amode_t;

  typedef enum logic [1:0] {
    ACC_READ  = 2'b00,
    ACC_WRITE = 2'b01,
    ACC_EXEC  = 2'b10
  } pmp_acc_t;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'b00,
    CHK_SCAN = 2'b01,
    CHK_RESP = 2'b10
  } pmp_chk_state_t;

  localparam int unsigned PMP_L_BIT = 7;
  localparam logic [1:0]  PRIV_M    = 2'b00;

endpackage

// File: rtl/pmp_access_checker_entry_match.sv
// Combinational address match and permission decode for one PMP entry.
module pmp_entry_match
  import pmp_access_checker_pkg::*;
(
  input  logic [7:0]  cfg,
  input  logic [31:0] pmpaddr,
  input  logic [31:0] pmpaddr_prev,
  input  logic [31:0] addr,
  input  logic        is_entry0,
  output logic        match,
  output logic        r,
  output logic        w,
  output logic        x,
  output logic        l
);

  pmp_amode_t  amode;
  logic [31:0] lower;
  logic [31:0] napot_mask;
  logic        unused_cfg_bits;

  assign unused_cfg_bits = ^cfg[6:5];

  always_comb begin
    amode = pmp_amode_t'(cfg[4:3]);
    lower = is_entry0 ? 32'd0 : pmpaddr_prev;
    // x ^ (x + 1) sets the trailing-ones run plus the first zero; all-ones yields an all-zero mask
    napot_mask = ~(pmpaddr ^ (pmpaddr + 32'd1));
    case (amode)
      PMP_TOR:   match = (lower < pmpaddr) && (addr >= lower) && (addr < pmpaddr);
      PMP_NA4:   match = (addr == pmpaddr);
      PMP_NAPOT: match = ((addr ^ pmpaddr) & napot_mask) == 32'd0;
      default:   match = 1'b0;
    endcase
    r = cfg[0];
    w = cfg[1] & cfg[0];
    x = cfg[2];
    l = cfg[PMP_L_BIT];
  end

endmodule

// File: rtl/pmp_access_checker.sv
// Sequential PMP checker: scans one entry per cycle, lowest index first.
// Optional fault capture is enabled by defining PMP_FAULT_CAPTURE_EN.
module pmp_access_checker
  import pmp_access_checker_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pmpcfg0_data,
  input  logic [31:0] pmpcfg1_data,
  input  logic [31:0] pmpcfg2_data,
  input  logic [31:0] pmpcfg3_data,
  input  logic [31:0] pmpaddr0_data,
  input  logic [31:0] pmpaddr1_data,
  input  logic [31:0] pmpaddr2_data,
  input  logic [31:0] pmpaddr3_data,
  input  logic [31:0] pmpaddr4_data,
  input  logic [31:0] pmpaddr5_data,
  input  logic [31:0] pmpaddr6_data,
  input  logic [31:0] pmpaddr7_data,
  input  logic [31:0] pmpaddr8_data,
  input  logic [31:0] pmpaddr9_data,
  input  logic [31:0] pmpaddr10_data,
  input  logic [31:0] pmpaddr11_data,
  input  logic [31:0] pmpaddr12_data,
  input  logic [31:0] pmpaddr13_data,
  input  logic [31:0] pmpaddr14_data,
  input  logic [31:0] pmpaddr15_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_type,
  input  logic [1:0]  req_priv,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_allow,
  output logic        resp_match,
  output logic [3:0]  resp_idx
`ifdef PMP_FAULT_CAPTURE_EN
  ,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic [1:0]  fault_type,
  input  logic        fault_clr
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

  pmp_chk_state_t state_q, state_d;
  logic [3:0]  idx_q, idx_d, ridx_q, ridx_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d, priv_q, priv_d;
  logic        allow_q, allow_d, match_q, match_d;

  logic [31:0] cfg_words [4];
  logic [31:0] addr_words [16];
  logic [7:0]  cfg_byte;
  logic [31:0] cur_addr, prev_addr;
  logic        ent_match, ent_r, ent_w, ent_x, ent_l;
  logic        perm, allow, scan_done;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr_q[1:0];

  always_comb begin
    cfg_words[0]   = pmpcfg0_data;   cfg_words[1]   = pmpcfg1_data;
    cfg_words[2]   = pmpcfg2_data;   cfg_words[3]   = pmpcfg3_data;
    addr_words[0]  = pmpaddr0_data;  addr_words[1]  = pmpaddr1_data;
    addr_words[2]  = pmpaddr2_data;  addr_words[3]  = pmpaddr3_data;
    addr_words[4]  = pmpaddr4_data;  addr_words[5]  = pmpaddr5_data;
    addr_words[6]  = pmpaddr6_data;  addr_words[7]  = pmpaddr7_data;
    addr_words[8]  = pmpaddr8_data;  addr_words[9]  = pmpaddr9_data;
    addr_words[10] = pmpaddr10_data; addr_words[11] = pmpaddr11_data;
    addr_words[12] = pmpaddr12_data; addr_words[13] = pmpaddr13_data;
    addr_words[14] = pmpaddr14_data; addr_words[15] = pmpaddr15_data;
    // Live CSR values: whatever is present in this scan cycle is what gets evaluated
    cfg_byte  = cfg_words[idx_q[3:2]][8*idx_q[1:0] +: 8];
    cur_addr  = addr_words[idx_q];
    prev_addr = addr_words[idx_q - 4'd1];
  end

  pmp_entry_match u_entry_match (
    .cfg          (cfg_byte),
    .pmpaddr      (cur_addr),
    .pmpaddr_prev (prev_addr),
    .addr         ({2'b00, addr_q[31:2]}),
    .is_entry0    (idx_q == 4'd0),
    .match        (ent_match),
    .r            (ent_r),
    .w            (ent_w),
    .x            (ent_x),
    .l            (ent_l)
  );

  always_comb begin
    case (type_q)
      ACC_READ:  perm = ent_r;
      ACC_WRITE: perm = ent_w;
      ACC_EXEC:  perm = ent_x;
      default:   perm = 1'b0;
    endcase
    if (type_q == 2'b11)     allow = 1'b0;
    else if (ent_match)      allow = (priv_q == PRIV_M) ? (ent_l ? perm : 1'b1) : perm;
    else                     allow = (priv_q == PRIV_M);
    scan_done = ent_match || (idx_q == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    type_d  = type_q;
    priv_d  = priv_q;
    allow_d = allow_q;
    match_d = match_q;
    ridx_d  = ridx_q;
    case (state_q)
      CHK_IDLE: begin
        if (req_valid) begin
          state_d = CHK_SCAN;
          idx_d   = 4'd0;
          addr_d  = req_addr;
          type_d  = req_type;
          priv_d  = req_priv;
        end
      end
      CHK_SCAN: begin
        if (scan_done) begin
          state_d = CHK_RESP;
          allow_d = allow;
          match_d = ent_match;
          ridx_d  = ent_match ? idx_q : 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      CHK_RESP: begin
        if (resp_ready) state_d = CHK_IDLE;
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CHK_IDLE;
      idx_q   <= 4'd0;
      addr_q  <= 32'd0;
      type_q  <= 2'd0;
      priv_q  <= 2'd0;
      allow_q <= 1'b0;
      match_q <= 1'b0;
      ridx_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      priv_q  <= priv_d;
      allow_q <= allow_d;
      match_q <= match_d;
      ridx_q  <= ridx_d;
    end
  end

  assign req_ready  = (state_q == CHK_IDLE);
  assign resp_valid = (state_q == CHK_RESP);
  assign resp_allow = allow_q;
  assign resp_match = match_q;
  assign resp_idx   = ridx_q;

`ifdef PMP_FAULT_CAPTURE_EN
  logic        fvalid_q;
  logic [31:0] faddr_q;
  logic [1:0]  ftype_q;
  logic        deny_event;

  assign deny_event = (state_q == CHK_SCAN) && scan_done && !allow;

  // A coinciding clear and denial keeps the new denial
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fvalid_q <= 1'b0;
      faddr_q  <= 32'd0;
      ftype_q  <= 2'd0;
    end else if (deny_event && (!fvalid_q || fault_clr)) begin
      fvalid_q <= 1'b1;
      faddr_q  <= addr_q;
      ftype_q  <= type_q;
    end else if (fault_clr) begin
      fvalid_q <= 1'b0;
      faddr_q  <= 32'd0;
      ftype_q  <= 2'd0;
    end
  end

  assign fault_valid = fvalid_q;
  assign fault_addr  = faddr_q;
  assign fault_type  = ftype_q;
`endif

endmodule
